// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request feeding a DEPTH-entry instruction queue.
// Latency: ack in cycle N makes the word visible at the queue head in N+1; issue is one cycle after the decision.
// Backpressure: a request is only issued when a queue slot is free; instr_ready low fills the queue and stalls issue. Optional FETCH_PERF_EN adds perf counters.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_ack,
    input  logic [31:0]               imem_rdata,
    output logic                      instr_valid,
    output logic [31:0]               instr,
    output logic [31:0]               instr_pc,
    output logic [31:0]               instr_pc4,
    input  logic                      instr_ready,
    output logic [$clog2(DEPTH):0]    fifo_count
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_flushed
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state_q;
    logic [31:0]   fetch_pc_q;
    logic          imem_req_q;
    logic [31:0]   imem_addr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [31:0]   mem_pc_q  [DEPTH];
    logic [31:0]   mem_dat_q [DEPTH];

    logic          push;
    logic          pop;
    logic [31:0]   pc_seq;
    logic [31:0]   redirect_tgt;
    logic          unused_redirect_lsb;

    // The low two bits of a redirect target are discarded by word alignment.
    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign pc_seq              = fetch_pc_q + 32'd4;

    // Redirect beats both push and pop; data returned while flushing is dropped.
    assign push = (state_q == S_WAIT) && imem_ack && !redirect && !rst;
    assign pop  = instr_valid && instr_ready && !redirect;

    // Occupancy after this cycle, used both for the register and the keep-fetching decision.
    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Fetch FSM, fetch PC, request outputs and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            count_q <= count_d;
            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_tgt;
                    end else if (en && (count_q < DEPTH_C)) begin
                        state_q     <= S_WAIT;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= fetch_pc_q;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            fetch_pc_q <= redirect_tgt;
                            state_q    <= S_IDLE;
                            imem_req_q <= 1'b0;
                        end else begin
                            fetch_pc_q <= pc_seq;
                            // Only chain the next request if its data is guaranteed a slot.
                            if (en && (count_d < DEPTH_C)) begin
                                imem_addr_q <= pc_seq;
                            end else begin
                                state_q    <= S_IDLE;
                                imem_req_q <= 1'b0;
                            end
                        end
                    end else if (redirect) begin
                        // Request stays on the bus until acked; its data is thrown away.
                        fetch_pc_q <= redirect_tgt;
                        state_q    <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (redirect) fetch_pc_q <= redirect_tgt;
                    if (imem_ack) begin
                        state_q    <= S_IDLE;
                        imem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Queue storage: {pc, word} written at the tail on every accepted ack.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]  <= fetch_pc_q;
            mem_dat_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign fifo_count  = count_q;
    assign instr_valid = (count_q != '0);
    // Head fields read as zero when the queue is empty so reset values are clean.
    assign instr       = instr_valid ? mem_dat_q[rd_ptr_q] : 32'd0;
    assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q] : 32'd0;
    assign instr_pc4   = instr_valid ? (mem_pc_q[rd_ptr_q] + 32'd4) : 32'd0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    // Saturating event counters: accepted fetches and redirect cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            if (push && (perf_fetched_q != 32'hFFFF_FFFF)) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect && (perf_flushed_q != 32'hFFFF_FFFF)) perf_flushed_q <= perf_flushed_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios then randomized traffic.
// Memory responder with programmable latency; delivered-stream reference model.
// Decode backpressure and redirects driven from the main sequence.
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_ready;
    logic [2:0]  fifo_count;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_pc4(instr_pc4),
        .instr_ready(instr_ready), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Contents of instruction memory as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_C3A5;
    endfunction

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: each request is acked after a latency of fixed_lat cycles
    // (or a random 0..3 when fixed_lat is negative).
    int fixed_lat = 0;
    bit resp_active = 1'b0;
    int resp_waited = 0;
    int resp_target = 0;
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req) begin
                if (!resp_active) begin
                    resp_active = 1'b1;
                    resp_waited = 0;
                    resp_target = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
                end
                if (resp_waited >= resp_target) begin
                    imem_ack    = 1'b1;
                    imem_rdata  = mem_word(imem_addr);
                    resp_active = 1'b0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    resp_waited++;
                end
            end else begin
                imem_ack    = 1'b0;
                imem_rdata  = $urandom;
                resp_active = 1'b0;
            end
        end
    end

    // Reference model: after reset or a redirect, decode must see target, target+4, ...
    // each with the memory word of its own address. Also checks request hold rules.
    bit          mon_on = 1'b0;
    logic [31:0] model_pc = RESET_PC;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic        prev_rst = 1'b1;
    logic [31:0] prev_addr = 32'd0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (rst) begin
                    model_pc = RESET_PC;
                end else if (redirect) begin
                    model_pc = {redirect_pc[31:2], 2'b00};
                end else if (instr_valid && instr_ready) begin
                    chk("pop_pc", instr_pc, model_pc);
                    chk("pop_instr", instr, mem_word(model_pc));
                    chk("pop_pc4", instr_pc4, model_pc + 32'd4);
                    model_pc = model_pc + 32'd4;
                end
                chk("valid_vs_count", 32'(instr_valid), 32'(fifo_count != 3'd0));
                chk("count_le_depth", 32'(fifo_count <= 3'(DEPTH)), 32'd1);
                chk("addr_aligned", 32'(imem_addr[1:0]), 32'd0);
                if (prev_req && !prev_ack && !prev_rst) begin
                    chk("req_hold", 32'(imem_req), 32'd1);
                    chk("addr_hold", imem_addr, prev_addr);
                end
                prev_req  = imem_req;
                prev_ack  = imem_ack;
                prev_rst  = rst;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        fixed_lat   = 0;
        cyc();
        mon_on = 1'b1;
        cyc();

        // Reset state
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_pc4", instr_pc4, 32'd0);

        // Zero-wait streaming with wrap of the PC through zero
        rst = 1'b0; en = 1'b1; instr_ready = 1'b1;
        cyc();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'hFFFF_FFF8);
        chk("first_valid", 32'(instr_valid), 32'd0);
        cyc();
        chk("s1_valid", 32'(instr_valid), 32'd1);
        chk("s1_pc", instr_pc, 32'hFFFF_FFF8);
        chk("s1_pc4", instr_pc4, 32'hFFFF_FFFC);
        chk("s1_addr", imem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("s2_pc", instr_pc, 32'hFFFF_FFFC);
        chk("s2_pc4", instr_pc4, 32'h0000_0000);
        chk("s2_addr", imem_addr, 32'h0000_0000);
        cyc();
        chk("s3_pc", instr_pc, 32'h0);
        chk("s3_pc4", instr_pc4, 32'h4);
        chk("s3_count", 32'(fifo_count), 32'd1);
        cyc();
        chk("s4_pc", instr_pc, 32'h4);
        chk("s4_pc4", instr_pc4, 32'h8);
        cyc();
        chk("s5_pc", instr_pc, 32'h8);
        chk("s5_pc4", instr_pc4, 32'hC);

        // Reset while a request is being acked
        rst = 1'b1;
        cyc();
        chk("rstack_count", 32'(fifo_count), 32'd0);
        chk("rstack_valid", 32'(instr_valid), 32'd0);
        chk("rstack_req", 32'(imem_req), 32'd0);
        chk("rstack_addr", imem_addr, RESET_PC);

        // Fill a stalled queue: exactly DEPTH pushes, then no requests
        rst = 1'b0; instr_ready = 1'b0;
        repeat (12) cyc();
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_req", 32'(imem_req), 32'd0);
        chk("full_head", instr_pc, 32'hFFFF_FFF8);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        chk("pop1_count", 32'(fifo_count), 32'd3);
        chk("pop1_req", 32'(imem_req), 32'd0);
        chk("pop1_head", instr_pc, 32'hFFFF_FFFC);
        cyc();
        chk("refill_req", 32'(imem_req), 32'd1);
        chk("refill_addr", imem_addr, 32'h8);
        cyc();
        chk("refull_count", 32'(fifo_count), 32'd4);
        chk("refull_req", 32'(imem_req), 32'd0);

        // Drain, then redirect while a slow request is outstanding
        en = 1'b0; instr_ready = 1'b1;
        repeat (6) cyc();
        chk("drain_count", 32'(fifo_count), 32'd0);
        fixed_lat = 3; en = 1'b1;
        cyc();
        chk("slow_req", 32'(imem_req), 32'd1);
        chk("slow_addr", imem_addr, 32'hC);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_1003;
        cyc();
        redirect = 1'b0;
        chk("disc_req", 32'(imem_req), 32'd1);
        chk("disc_addr", imem_addr, 32'hC);
        chk("disc_valid", 32'(instr_valid), 32'd0);
        cyc();
        chk("disc2_addr", imem_addr, 32'hC);
        cyc();
        chk("disc_done_req", 32'(imem_req), 32'd0);
        chk("disc_done_count", 32'(fifo_count), 32'd0);
        fixed_lat = 0;
        cyc();
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_1000);

        // Redirect coincident with an ack while two entries are queued
        instr_ready = 1'b0;
        for (int i = 0; i < 20 && fifo_count != 3'd2; i++) cyc();
        chk("two_count", 32'(fifo_count), 32'd2);
        chk("two_req", 32'(imem_req), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        cyc();
        redirect = 1'b0;
        chk("coinc_count", 32'(fifo_count), 32'd0);
        chk("coinc_valid", 32'(instr_valid), 32'd0);
        chk("coinc_req", 32'(imem_req), 32'd0);
        cyc();
        chk("coinc_next_addr", imem_addr, 32'h0000_2000);
        chk("coinc_next_req", 32'(imem_req), 32'd1);

        // Randomized traffic checked by the reference model
        fixed_lat = -1;
        repeat (600) begin
            en          = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            rst         = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 1'b0; redirect = 1'b0; en = 1'b0; instr_ready = 1'b1;
        repeat (10) cyc();
        chk("end_count", 32'(fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port: en  input  1  fetch enable; low blocks new memory requests.
REQ-007 SHALL have port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-008 SHALL have port: redirect_pc  input  32  new fetch target.
REQ-009 SHALL have port: imem_req  output  1  instruction memory request, registered.
REQ-010 SHALL have port: imem_addr  output  32  request address, registered, word aligned.
REQ-011 SHALL have port: imem_ack  input  1  request complete; imem_rdata valid this cycle.
REQ-012 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-013 SHALL have port: instr_valid  output  1  queue head valid to decode.
REQ-014 SHALL have port: instr  output  32  queue head instruction.
REQ-015 SHALL have port: instr_pc  output  32  address of instr.
REQ-016 SHALL have port: instr_pc4  output  32  instr_pc + 4, mod 2^32.
REQ-017 SHALL have port: instr_ready  input  1  decode accepts head this cycle.
REQ-018 SHALL have port: fifo_count  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-019 SHALL implement FSM states IDLE (no request), WAIT (request outstanding), DISCARD (outstanding request to be dropped).
REQ-020 SHALL allow at most one outstanding request; imem_req and imem_addr held stable from assertion until the cycle imem_ack is sampled high.
REQ-021 SHALL transition IDLE->WAIT and assert imem_req next cycle with imem_addr=fetch_pc when en=1, redirect=0, fifo_count<DEPTH.
REQ-022 SHALL, on imem_ack in WAIT without redirect: push {fetch_pc, imem_rdata}, fetch_pc += 4 (wraps 32'hFFFF_FFFC->0); stay WAIT with new address next cycle if en=1 and post-push count<DEPTH, else go IDLE and drop imem_req.
REQ-023 SHALL pop head when instr_valid&&instr_ready; simultaneous push and pop leaves count unchanged; instr_valid = (fifo_count!=0).
REQ-024 SHALL make pushed data visible at head one cycle after the ack cycle when queue empty (ack in cycle N -> instr_valid in N+1).
REQ-025 SHALL on redirect: empty queue (instr_valid=0 next cycle, pop ignored), fetch_pc <= {redirect_pc[31:2],2'b00}; redirect has priority over push and pop.
REQ-026 SHALL on redirect in WAIT without same-cycle ack go DISCARD, keep old imem_req/imem_addr until ack, drop that data, then go IDLE.
REQ-027 SHALL on redirect coincident with imem_ack drop the returned data and go IDLE; redirect in DISCARD updates fetch_pc only.
REQ-028 SHALL, when en falls in WAIT, complete and push the outstanding request, then go IDLE.
REQ-029 SHALL never push when full; issue rule of REQ-021/022 guarantees a slot for every ack.

Reset
REQ-030 SHALL on rst: state IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, fifo_count=0, instr_valid=0, instr=0, instr_pc=0, instr_pc4=0; rst overrides all inputs including imem_ack and redirect; ack arriving after rst is ignored.

Configuration
REQ-031 SHALL, when FETCH_PERF_EN is defined, add outputs perf_fetched (32, counts pushes) and perf_flushed (32, counts redirect cycles), both saturating at 32'hFFFF_FFFF and cleared by rst; when undefined, these ports and counters SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: rst then en=1, zero-wait ack every cycle, instr_ready=1 -> instr_pc sequence 0x0,0x4,0x8, instr_pc4 0x4,0x8,0xC.
REQ-033 SHALL cover: DEPTH=4, instr_ready=0 -> exactly 4 pushes, fifo_count=4, imem_req=0 until a pop.
REQ-034 SHALL cover: redirect_pc=0x0000_1003 while ack pending 3 cycles -> DISCARD, stale data dropped, next imem_addr=0x0000_1000.
REQ-035 SHALL cover: redirect and imem_ack same cycle, count=2 -> fifo_count=0, instr_valid=0 next cycle, no push.
REQ-036 SHALL cover: RESET_PC=0xFFFF_FFF8, two acks -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, next imem_addr=0x0, instr_pc4 of second=0x0.
REQ-037 SHALL cover: rst asserted in WAIT with imem_ack same cycle -> no push, fifo_count=0, imem_req=0, imem_addr=RESET_PC.
